// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and widths for the memory bus interface
package mem_if_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - wait-state counter with terminal count at WAIT_CYCLES-1
module mem_wait_counter
    import mem_if_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - MAR/MDR registers and fixed-wait-state SRAM handshake
module mem_bus_interface
    import mem_if_pkg::*;
#(
    parameter int WORD_W      = mem_if_pkg::WORD_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [WORD_W-1:0] Bus_In,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Start,
    input  logic              Mem_Write,
    input  logic [WORD_W-1:0] Mem_RData,
    output logic [WORD_W-1:0] MAR_Out,
    output logic [WORD_W-1:0] MDR_Out,
    output logic [WORD_W-1:0] Mem_Addr,
    output logic [WORD_W-1:0] Mem_WData,
    output logic              Mem_CE_n,
    output logic              Mem_OE_n,
    output logic              Mem_WE_n,
    output logic              Mem_Ready,
    output logic              Busy
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_bus_interface: WAIT_CYCLES must be in 1..15");
    end

    mem_state_t        state, state_nxt;
    logic [WORD_W-1:0] mar, mdr;
    logic              is_write;
    logic              cnt_tc;

    mem_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clr    (state == IDLE),
        .en     (state == ACCESS),
        .tc     (cnt_tc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= '0;
            is_write <= 1'b0;
        end else begin
            state <= state_nxt;
            // Loads are only honoured in IDLE so address/data hold during an access.
            if (state == IDLE) begin
                if (LD_MAR) begin
                    mar <= Bus_In;
                end
                if (LD_MDR) begin
                    mdr <= Bus_In;
                end
                if (Mem_Start) begin
                    is_write <= Mem_Write;
                end
            end
            if (state == ACCESS && cnt_tc && !is_write) begin
                mdr <= Mem_RData;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Mem_Start) state_nxt = ACCESS;
            ACCESS:  if (cnt_tc)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode from registered state only: no input-to-output path.
    always_comb begin
        Mem_CE_n  = 1'b1;
        Mem_OE_n  = 1'b1;
        Mem_WE_n  = 1'b1;
        Mem_Ready = 1'b0;
        Busy      = 1'b0;
        case (state)
            ACCESS: begin
                Mem_CE_n = 1'b0;
                Mem_OE_n = is_write;
                Mem_WE_n = !is_write;
                Busy     = 1'b1;
            end
            DONE: begin
                Mem_Ready = 1'b1;
                Busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign MAR_Out   = mar;
    assign MDR_Out   = mdr;
    assign Mem_Addr  = mar;
    assign Mem_WData = mdr;

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - directed vector bench for mem_bus_interface
module tb_mem_bus_interface;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Bus_In;
    logic        LD_MAR, LD_MDR, Mem_Start, Mem_Write;
    logic [15:0] Mem_RData;

    logic [15:0] a_mar, a_mdr, a_addr, a_wdata;
    logic        a_ce, a_oe, a_we, a_rdy, a_busy;
    logic [15:0] b_mar, b_mdr, b_addr, b_wdata;
    logic        b_ce, b_oe, b_we, b_rdy, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    mem_bus_interface #(.WORD_W(16), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_Start(Mem_Start), .Mem_Write(Mem_Write), .Mem_RData(Mem_RData),
        .MAR_Out(a_mar), .MDR_Out(a_mdr), .Mem_Addr(a_addr), .Mem_WData(a_wdata),
        .Mem_CE_n(a_ce), .Mem_OE_n(a_oe), .Mem_WE_n(a_we), .Mem_Ready(a_rdy), .Busy(a_busy)
    );

    mem_bus_interface #(.WORD_W(16), .WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Bus_In(Bus_In), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_Start(Mem_Start), .Mem_Write(Mem_Write), .Mem_RData(Mem_RData),
        .MAR_Out(b_mar), .MDR_Out(b_mdr), .Mem_Addr(b_addr), .Mem_WData(b_wdata),
        .Mem_CE_n(b_ce), .Mem_OE_n(b_oe), .Mem_WE_n(b_we), .Mem_Ready(b_rdy), .Busy(b_busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld_mar, ld_mdr, start, wr;
        logic [15:0] bus, rdata;
        logic [15:0] e_mar, e_mdr;
        logic        e_ce, e_oe, e_we, e_rdy, e_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Read of 3000 -> BEEF, then write 00FF to 1234 with lockout pokes during ACCESS/DONE.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h3000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h3000, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3000, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h5555, 16'h1234, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h5555, 16'h1234, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h5555, 16'h1234, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        Reset_n = 1'b0;
        Bus_In = '0; LD_MAR = 0; LD_MDR = 0; Mem_Start = 0; Mem_Write = 0; Mem_RData = '0;

        for (int r = 0; r < 3; r++) begin
            Bus_In    = 16'($urandom);
            Mem_RData = 16'($urandom);
            LD_MAR    = 1'($urandom);
            LD_MDR    = 1'($urandom);
            Mem_Start = 1'($urandom);
            Mem_Write = 1'($urandom);
            @(posedge Clk); #1;
            chk($sformatf("rst%0d mar", r), a_mar, 16'h0);
            chk($sformatf("rst%0d mdr", r), a_mdr, 16'h0);
            chk($sformatf("rst%0d ce_n", r), a_ce, 16'h1);
            chk($sformatf("rst%0d oe_n", r), a_oe, 16'h1);
            chk($sformatf("rst%0d we_n", r), a_we, 16'h1);
            chk($sformatf("rst%0d ready", r), a_rdy, 16'h0);
            chk($sformatf("rst%0d busy", r), a_busy, 16'h0);
        end
        @(negedge Clk);
        Bus_In = '0; LD_MAR = 0; LD_MDR = 0; Mem_Start = 0; Mem_Write = 0; Mem_RData = '0;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("post-rst busy", a_busy, 16'h0);
        chk("post-rst ce_n", a_ce, 16'h1);

        for (int i = 0; i < 11; i++) begin
            LD_MAR = vecs[i].ld_mar; LD_MDR = vecs[i].ld_mdr;
            Mem_Start = vecs[i].start; Mem_Write = vecs[i].wr;
            Bus_In = vecs[i].bus; Mem_RData = vecs[i].rdata;
            @(posedge Clk); #1;
            chk($sformatf("v%0d mar", i), a_mar, vecs[i].e_mar);
            chk($sformatf("v%0d addr", i), a_addr, vecs[i].e_mar);
            chk($sformatf("v%0d mdr", i), a_mdr, vecs[i].e_mdr);
            chk($sformatf("v%0d wdata", i), a_wdata, vecs[i].e_mdr);
            chk($sformatf("v%0d ce_n", i), a_ce, vecs[i].e_ce);
            chk($sformatf("v%0d oe_n", i), a_oe, vecs[i].e_oe);
            chk($sformatf("v%0d we_n", i), a_we, vecs[i].e_we);
            chk($sformatf("v%0d ready", i), a_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d busy", i), a_busy, vecs[i].e_busy);
        end
        LD_MAR = 0; LD_MDR = 0; Mem_Start = 0; Mem_Write = 0; Bus_In = '0; Mem_RData = '0;

        // Asynchronous reset in the first ACCESS cycle of a read.
        Mem_Start = 1'b1; Mem_Write = 1'b0; Mem_RData = 16'h9999;
        @(posedge Clk); #1;
        Mem_Start = 1'b0;
        chk("midrst ce_n before", a_ce, 16'h0);
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst ce_n", a_ce, 16'h1);
        chk("midrst oe_n", a_oe, 16'h1);
        chk("midrst we_n", a_we, 16'h1);
        chk("midrst busy", a_busy, 16'h0);
        chk("midrst mdr", a_mdr, 16'h0);
        #2 Reset_n = 1'b1;
        @(posedge Clk); #1;
        Mem_RData = 16'h1357; Mem_Start = 1'b1;
        @(posedge Clk); #1;
        Mem_Start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (a_rdy) break;
            @(posedge Clk); #1;
        end
        chk("reread ready", a_rdy, 16'h1);
        chk("reread mdr", a_mdr, 16'h1357);

        // Back-to-back reads on the single-wait-state instance.
        repeat (3) begin
            @(posedge Clk); #1;
        end
        chk("b2b idle busy", b_busy, 16'h0);
        Mem_Start = 1'b1; Mem_Write = 1'b0;
        for (int c = 0; c < 9; c++) begin
            Mem_RData = 16'(16'hC000 + c);
            @(posedge Clk); #1;
            chk($sformatf("b2b c%0d ready", c), b_rdy, 16'(c % 3 == 1));
            chk($sformatf("b2b c%0d busy", c), b_busy, 16'(c % 3 != 2));
            if (c % 3 == 1) begin
                chk($sformatf("b2b c%0d mdr", c), b_mdr, 16'(16'hC000 + c));
            end
        end
        Mem_Start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
